divider_modulo: RTL and testbench
=================================

# divider_modulo

Fully pipelined unsigned 32-bit by 16-bit non-restoring divider. A per-operation `mode` bit selects whether the quotient or the remainder is returned. It accepts one operation per clock and sits in the datapath as a fixed-latency arithmetic unit. Results leave in issue order, qualified by `valid_out`.

## Interface
- No parameters; all widths are fixed.
- `clk`  input  1  Single clock; all state updates on its rising edge.
- `reset`  input  1  Asynchronous, active-low reset.
- `mode`  input  1  Result select, sampled with `valid_in`: 0 = quotient, 1 = remainder (modulo).
- `valid_in`  input  1  High when an operation is presented this cycle; no backpressure.
- `divisor`  input  16  Unsigned divisor.
- `dividend`  input  32  Unsigned dividend.
- `result`  output  32  Quotient (mode 0) or zero-extended 16-bit remainder (mode 1).
- `valid_out`  output  1  High for exactly one cycle per accepted operation, when `result` is valid.

## Operation
- Algorithm: non-restoring division, one quotient bit per pipeline stage, 32 stages, MSB first.
- Partial remainder is 17 bits signed.
  - Each stage: if the partial remainder is ≥0, shift left, bring in the next dividend bit and subtract the divisor; otherwise shift, bring in the bit and add the divisor.
  - The quotient bit is 1 when the new partial remainder is ≥0.
- Final correction after stage 32: if the remainder is negative, add the divisor once.
- The quotient is the 32 collected bits; no correction is needed for it.
- Each stage carries its own copy of `divisor`, `mode`, the partial remainder, the remaining dividend bits, the quotient bits and a valid bit. Operations never interact.
- `valid_in` low inserts a bubble: that stage's valid bit is 0 and its data is don't-care.
- Output stage:
  - mode 0: `result` = quotient.
  - mode 1: `result` = {16'b0, remainder}.
- Divide by zero (divisor = 0):
  - mode 0: `result` = 32'hFFFF_FFFF.
  - mode 1: `result` = dividend.
  - Implemented by an explicit zero flag carried down the pipe.
- `result` holds its last valid value while `valid_out` is low.

## Timing
- Latency: operation sampled at rising edge N (`valid_in`=1) → `result`/`valid_out` updated at edge N+33. This is 32 iteration stages plus one correction/output register.
- Throughput: one operation per cycle, back-to-back, with no dead cycles.
- Reset (`reset`=0, asynchronous):
  - `result` = 0, `valid_out` = 0, all stage valid bits = 0.
  - Data registers need not be reset.
- Reset asserted mid-operation: all in-flight operations are discarded and no `valid_out` follows for them.
- The first edge after reset release may accept an operation.
- `mode`, `divisor` and `dividend` are don't-care when `valid_in` = 0.

## Configuration
- `DIVIDER_MODULO_DBZ_EN`:
  - Defined: adds output port `div_by_zero` (1 bit, reset 0). It is aligned with `valid_out` and high when the returned operation had divisor = 0. `div_by_zero` is low whenever `valid_out` is low.
  - Undefined: the port and its pipeline flag are absent. The `result` values for divide by zero are unchanged.

## Test plan
- Reset held low with random inputs → `valid_out` = 0 and `result` = 0 throughout. After release, first result appears 33 cycles after the first accepted `valid_in`.
- Mode 0: divisor 25347, dividend 537133248 → `result` = 21191. Same operands in mode 1 → `result` = 4971.
- Back-to-back operations:
  - Edge N: mode 0, 25347 / 537133248.
  - Edge N+1: mode 1, 25443 / 690275523.
  - Expected → `result` = 21191 at N+33 and `result` = 6933 at N+34, `valid_out` high for both cycles.
- Quotient wider than 16 bits: mode 0, divisor 3, dividend 537133248 → `result` = 179044416. Mode 1 → `result` = 0.
- Edges: divisor 1, dividend 32'hFFFF_FFFF → quotient 32'hFFFF_FFFF, remainder 0. Divisor 16'hFFFF, dividend 16'hFFFE → quotient 0, remainder 65534.
- Divide by zero: divisor 0, dividend 1234 → mode 0 `result` 32'hFFFF_FFFF; mode 1 `result` 1234. With `DIVIDER_MODULO_DBZ_EN`, `div_by_zero` = 1. Reset pulsed with 5 operations in flight → no `valid_out` afterwards.

Source files
------------

// File: rtl/divider_modulo_if.sv
// rtl/divider_modulo_if.sv - operand/result bundle for divider_modulo; DIVIDER_MODULO_DBZ_EN adds div_by_zero
interface divider_modulo_if;
  logic        mode;
  logic        valid_in;
  logic [15:0] divisor;
  logic [31:0] dividend;
  logic [31:0] result;
  logic        valid_out;
`ifdef DIVIDER_MODULO_DBZ_EN
  logic        div_by_zero;

  modport master (
    output mode, valid_in, divisor, dividend,
    input  result, valid_out, div_by_zero
  );

  modport slave (
    input  mode, valid_in, divisor, dividend,
    output result, valid_out, div_by_zero
  );
`else
  modport master (
    output mode, valid_in, divisor, dividend,
    input  result, valid_out
  );

  modport slave (
    input  mode, valid_in, divisor, dividend,
    output result, valid_out
  );
`endif
endinterface

// File: rtl/divider_modulo.sv
// rtl/divider_modulo.sv - 33-cycle pipelined 32/16 non-restoring divider; DIVIDER_MODULO_DBZ_EN adds div_by_zero
module divider_modulo (
  input  logic            clk,
  input  logic            reset,
  divider_modulo_if.slave bus
);
  localparam int STAGES = 32;

  // Stage 0 holds the captured operands; stages 1..32 each retire one quotient bit.
  logic        vld  [0:STAGES];
  logic        md   [0:STAGES];
  logic [15:0] dvs  [0:STAGES];
  logic [16:0] prem [0:STAGES];
  logic [31:0] dq   [0:STAGES];
`ifdef DIVIDER_MODULO_DBZ_EN
  logic        zf   [0:STAGES];
`endif
  logic        zero [0:STAGES];

  logic [16:0] prem_nx [1:STAGES];
  logic [31:0] dq_nx   [1:STAGES];
  logic [15:0] rem_fix;
  logic [31:0] result_nx;

  // dq shifts dividend bits out of the MSB and quotient bits into the LSB.
  // With a zero divisor it rotates instead, so the original dividend survives.
  always_comb begin
    for (int k = 0; k <= STAGES; k++) begin
`ifdef DIVIDER_MODULO_DBZ_EN
      zero[k] = zf[k];
`else
      zero[k] = (dvs[k] == 16'd0);
`endif
    end
    for (int k = 1; k <= STAGES; k++) begin
      if (prem[k-1][16])
        prem_nx[k] = {prem[k-1][15:0], dq[k-1][31]} + {1'b0, dvs[k-1]};
      else
        prem_nx[k] = {prem[k-1][15:0], dq[k-1][31]} - {1'b0, dvs[k-1]};
      dq_nx[k] = {dq[k-1][30:0], zero[k-1] ? dq[k-1][31] : ~prem_nx[k][16]};
    end
  end

  always_comb begin
    rem_fix = prem[STAGES][16] ? (prem[STAGES][15:0] + dvs[STAGES]) : prem[STAGES][15:0];
    if (zero[STAGES])
      result_nx = md[STAGES] ? dq[STAGES] : 32'hFFFF_FFFF;
    else
      result_nx = md[STAGES] ? {16'd0, rem_fix} : dq[STAGES];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= STAGES; k++) vld[k] <= 1'b0;
    end else begin
      vld[0] <= bus.valid_in;
      for (int k = 1; k <= STAGES; k++) vld[k] <= vld[k-1];
    end
  end

  // Datapath registers carry no reset; bubbles and flushed slots are ignored via vld.
  always_ff @(posedge clk) begin
    md[0]   <= bus.mode;
    dvs[0]  <= bus.divisor;
    prem[0] <= 17'd0;
    dq[0]   <= bus.dividend;
`ifdef DIVIDER_MODULO_DBZ_EN
    zf[0]   <= (bus.divisor == 16'd0);
`endif
    for (int k = 1; k <= STAGES; k++) begin
      md[k]   <= md[k-1];
      dvs[k]  <= dvs[k-1];
      prem[k] <= prem_nx[k];
      dq[k]   <= dq_nx[k];
`ifdef DIVIDER_MODULO_DBZ_EN
      zf[k]   <= zf[k-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.result      <= 32'd0;
      bus.valid_out   <= 1'b0;
`ifdef DIVIDER_MODULO_DBZ_EN
      bus.div_by_zero <= 1'b0;
`endif
    end else begin
      bus.valid_out   <= vld[STAGES];
      if (vld[STAGES]) bus.result <= result_nx;
`ifdef DIVIDER_MODULO_DBZ_EN
      bus.div_by_zero <= vld[STAGES] & zf[STAGES];
`endif
    end
  end
endmodule

// File: tb/tb_divider_modulo.sv
// tb/tb_divider_modulo.sv - directed-vector bench for divider_modulo with result scoreboard
module tb_divider_modulo;
  logic clk   = 1'b0;
  logic reset = 1'b1;

  divider_modulo_if bus ();

  divider_modulo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          issue_edge;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_issued = 0;
  int          n_seen   = 0;
  logic [31:0] last_res = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      check_eq("reset_valid_out", {31'd0, bus.valid_out}, 32'd0);
      check_eq("reset_result", bus.result, 32'd0);
    end else if (bus.valid_out) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid_out", {31'd0, bus.valid_out}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        n_seen++;
        check_eq("result", bus.result, e.res);
        check_eq("latency", cyc, e.issue_edge + 33);
`ifdef DIVIDER_MODULO_DBZ_EN
        check_eq("div_by_zero", {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
`endif
        last_res = e.res;
      end
    end else begin
      check_eq("result_hold", bus.result, last_res);
`ifdef DIVIDER_MODULO_DBZ_EN
      check_eq("dbz_idle_low", {31'd0, bus.div_by_zero}, 32'd0);
`endif
    end
  end

  task automatic op(input logic m, input logic [15:0] dv, input logic [31:0] dd,
                    input logic [31:0] res, input logic rel);
    @(negedge clk);
    if (rel) reset = 1'b1;
    bus.mode     = m;
    bus.divisor  = dv;
    bus.dividend = dd;
    bus.valid_in = 1'b1;
    exp_q.push_back('{res: res, dbz: (dv == 16'd0), issue_edge: cyc + 1});
    n_issued++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      bus.mode     = 1'($urandom);
      bus.divisor  = 16'($urandom);
      bus.dividend = $urandom;
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.mode     = 1'b0;
    bus.divisor  = 16'd0;
    bus.dividend = 32'd0;
    #1 reset = 1'b0;

    // Reset held with random traffic, including valid_in pulses.
    repeat (8) begin
      @(negedge clk);
      bus.valid_in = 1'($urandom);
      bus.mode     = 1'($urandom);
      bus.divisor  = 16'($urandom);
      bus.dividend = $urandom;
    end

    op(1'b0, 16'd25347, 32'd537133248, 32'd21191, 1'b1);
    op(1'b1, 16'd25347, 32'd537133248, 32'd4971, 1'b0);
    op(1'b0, 16'd25347, 32'd537133248, 32'd21191, 1'b0);
    op(1'b1, 16'd25443, 32'd690275523, 32'd6933, 1'b0);
    op(1'b0, 16'd3, 32'd537133248, 32'd179044416, 1'b0);
    op(1'b1, 16'd3, 32'd537133248, 32'd0, 1'b0);
    op(1'b0, 16'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    op(1'b1, 16'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    op(1'b0, 16'hFFFF, 32'h0000_FFFE, 32'd0, 1'b0);
    op(1'b1, 16'hFFFF, 32'h0000_FFFE, 32'd65534, 1'b0);
    op(1'b0, 16'hFFFF, 32'hFFFF_FFFF, 32'd65537, 1'b0);
    op(1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    idle(3);
    op(1'b0, 16'd0, 32'd1234, 32'hFFFF_FFFF, 1'b0);
    op(1'b1, 16'd0, 32'd1234, 32'd1234, 1'b0);
    idle(2);
    op(1'b0, 16'd7, 32'd100, 32'd14, 1'b0);
    op(1'b1, 16'd7, 32'd100, 32'd2, 1'b0);
    op(1'b0, 16'd5, 32'd0, 32'd0, 1'b0);
    idle(40);

    // Flush five in-flight operations with an asynchronous reset pulse.
    op(1'b0, 16'd3, 32'd99, 32'd33, 1'b0);
    op(1'b1, 16'd3, 32'd100, 32'd1, 1'b0);
    op(1'b0, 16'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    op(1'b1, 16'd9, 32'd50, 32'd5, 1'b0);
    op(1'b0, 16'd2, 32'd8, 32'd4, 1'b0);
    idle(4);
    #2;
    reset = 1'b0;
    exp_q.delete();
    n_issued -= 5;
    last_res = 32'd0;
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    idle(45);

    op(1'b0, 16'd7, 32'd100, 32'd14, 1'b0);
    op(1'b1, 16'd7, 32'd100, 32'd2, 1'b0);
    idle(40);

    check_eq("queue_drained", exp_q.size(), 32'd0);
    check_eq("output_count", n_seen, n_issued);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
